// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game blocks.
package pong_pkg;

  localparam int SCORE_W  = 4;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    POINT,
    GAME_OVER
  } state_t;

  typedef struct packed {
    logic [SCORE_W-1:0] p1;
    logic [SCORE_W-1:0] p2;
  } score_t;

endpackage

// File: rtl/pong_btn_edge.sv
// Two-flop synchroniser for an active-low button plus a one-cycle press pulse.
module pong_btn_edge (
  input  logic clk_50,
  input  logic reset,
  input  logic btn_n,
  output logic press_pulse
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], btn_n};
      prev_q <= sync_q[1];
    end
  end

  // High for the single cycle after the synchronised level falls.
  assign press_pulse = prev_q & ~sync_q[1];

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer: idle, serve delay, live play, scoring and game over.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int GOAL_LEFT_X  = 2,
  parameter int GOAL_RIGHT_X = 633
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [9:0]         ball_x,
  input  logic               start_btn_n,
  output logic               ball_hold,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               point_pulse,
  output logic               game_over,
  output logic               winner
);

  localparam int                 CNT_W   = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [9:0]         GOAL_L  = 10'(GOAL_LEFT_X);
  localparam logic [9:0]         GOAL_R  = 10'(GOAL_RIGHT_X);
  localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);

  state_t           state_q, state_d;
  score_t           score_q, score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             winner_q, winner_d;
  logic             run_q, hold_q, pulse_q, over_q;
  logic             start_pulse;
  logic [SCORE_W-1:0] scorer_score;

  pong_btn_edge u_start (
    .clk_50      (clk_50),
    .reset       (reset),
    .btn_n       (start_btn_n),
    .press_pulse (start_pulse)
  );

  // serve_dir points at whoever conceded, so dir=1 means P1 just scored.
  assign scorer_score = dir_q ? score_q.p1 : score_q.p2;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          score_d = '0;
          dir_d   = 1'b1;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_END) state_d = PLAY;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (ball_x <= GOAL_L) begin
            score_d.p2 = score_q.p2 + SCORE_W'(1);
            dir_d      = 1'b0;
            state_d    = POINT;
          end else if (ball_x >= GOAL_R) begin
            score_d.p1 = score_q.p1 + SCORE_W'(1);
            dir_d      = 1'b1;
            state_d    = POINT;
          end
        end
      end
      POINT: begin
        if (scorer_score == WIN) begin
          winner_d = ~dir_q;
          state_d  = GAME_OVER;
        end else begin
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      GAME_OVER: begin
        if (start_pulse) begin
          score_d = '0;
          dir_d   = ~winner_q;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      score_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      winner_q <= 1'b0;
      run_q    <= 1'b0;
      hold_q   <= 1'b1;
      pulse_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      winner_q <= winner_d;
      run_q    <= (state_d == PLAY);
      hold_q   <= (state_d != PLAY);
      pulse_q  <= (state_d == POINT);
      over_q   <= (state_d == GAME_OVER);
    end
  end

  assign ball_hold   = hold_q;
  assign ball_run    = run_q;
  assign serve_dir   = dir_q;
  assign score_p1    = score_q.p1;
  assign score_p2    = score_q.p2;
  assign point_pulse = pulse_q;
  assign game_over   = over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench: a table of per-cycle vectors plus hand sequences for long flows.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int SF = 60;

  logic               clk_50 = 1'b0;
  logic               reset  = 1'b1;
  logic               frame_tick = 1'b0;
  logic [9:0]         ball_x = 10'd320;
  logic               start_btn_n = 1'b1;
  logic               ball_hold, ball_run, serve_dir, point_pulse, game_over, winner;
  logic [SCORE_W-1:0] score_p1, score_p2;

  int n_vec = 0;
  int n_bad = 0;

  pong_game_ctrl #(.SERVE_FRAMES(SF), .WIN_SCORE(7), .GOAL_LEFT_X(2), .GOAL_RIGHT_X(633)) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .ball_x      (ball_x),
    .start_btn_n (start_btn_n),
    .ball_hold   (ball_hold),
    .ball_run    (ball_run),
    .serve_dir   (serve_dir),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .point_pulse (point_pulse),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    string       name;
    int          rep;
    logic        tick;
    logic [9:0]  bx;
    logic        btn_n;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Output bundle: {hold, run, dir, p1[3:0], p2[3:0], pulse, over, winner}
  function automatic logic [13:0] e(input logic h, input logic r, input logic d,
                                    input logic [3:0] p1, input logic [3:0] p2,
                                    input logic pp, input logic go, input logic w);
    return {h, r, d, p1, p2, pp, go, w};
  endfunction

  function automatic vec_t mk(input string nm, input int rep, input logic tk,
                              input logic [9:0] bx, input logic bn, input logic [13:0] ex);
    vec_t v;
    v.name = nm; v.rep = rep; v.tick = tk; v.bx = bx; v.btn_n = bn; v.exp = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [13:0] ex);
    logic [13:0] got;
    got = {ball_hold, ball_run, serve_dir, score_p1, score_p2, point_pulse, game_over, winner};
    n_vec++;
    if (got !== ex) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (hold,run,dir,p1,p2,pulse,over,win)", nm, got, ex);
    end
  endtask

  task automatic step(input logic tk, input logic [9:0] bx, input logic bn);
    @(negedge clk_50);
    frame_tick  = tk;
    ball_x      = bx;
    start_btn_n = bn;
    @(posedge clk_50);
    #1;
  endtask

  task automatic serve_to_play(input logic [3:0] p1, input logic [3:0] p2, input logic d);
    for (int i = 0; i < SF - 1; i++) begin
      step(1'b1, 10'd320, 1'b1);
      chk("serve_hold", e(1, 0, d, p1, p2, 0, 0, 0));
    end
    step(1'b1, 10'd320, 1'b1);
    chk("serve_release", e(0, 1, d, p1, p2, 0, 0, 0));
  endtask

  task automatic p1_point(input logic [3:0] p1n, input logic [3:0] p2);
    step(1'b1, 10'd634, 1'b1);
    chk("p1_point", e(1, 0, 1, p1n, p2, 1, 0, 0));
    step(1'b0, 10'd320, 1'b1);
    if (p1n == 4'd7) chk("p1_wins", e(1, 0, 1, p1n, p2, 0, 1, 0));
    else             chk("p1_reserve", e(1, 0, 1, p1n, p2, 0, 0, 0));
  endtask

  // Button low at edge k; the new state shows after edge k+2.
  task automatic press_start(input string nm, input logic [13:0] ex);
    step(1'b0, 10'd320, 1'b0);
    step(1'b0, 10'd320, 1'b0);
    step(1'b0, 10'd320, 1'b0);
    chk(nm, ex);
    step(1'b0, 10'd320, 1'b1);
    step(1'b0, 10'd320, 1'b1);
    chk({nm, "_settled"}, ex);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

  initial begin
    tbl.push_back(mk("start_k",        1, 0, 320, 0, e(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk("start_k1",       1, 0, 320, 0, e(1,0,0,0,0,0,0,0)));
    tbl.push_back(mk("start_k2",       1, 0, 320, 0, e(1,0,1,0,0,0,0,0)));
    tbl.push_back(mk("start_held",     3, 0, 320, 0, e(1,0,1,0,0,0,0,0)));
    tbl.push_back(mk("btn_release",    2, 0, 320, 1, e(1,0,1,0,0,0,0,0)));
    tbl.push_back(mk("serve_59",      59, 1, 320, 1, e(1,0,1,0,0,0,0,0)));
    tbl.push_back(mk("serve_60",       1, 1, 320, 1, e(0,1,1,0,0,0,0,0)));
    tbl.push_back(mk("play_no_tick",   3, 0,   1, 1, e(0,1,1,0,0,0,0,0)));
    tbl.push_back(mk("p2_goal",        1, 1,   1, 1, e(1,0,0,0,1,1,0,0)));
    tbl.push_back(mk("point_to_serve", 1, 0, 320, 1, e(1,0,0,0,1,0,0,0)));
    tbl.push_back(mk("serve_59b",     59, 1, 320, 1, e(1,0,0,0,1,0,0,0)));
    tbl.push_back(mk("serve_60b",      1, 1, 320, 1, e(0,1,0,0,1,0,0,0)));
    tbl.push_back(mk("start_in_play",  4, 1, 320, 0, e(0,1,0,0,1,0,0,0)));
    tbl.push_back(mk("release_play",   3, 1, 320, 1, e(0,1,0,0,1,0,0,0)));
    tbl.push_back(mk("x3_no_goal",     1, 1,   3, 1, e(0,1,0,0,1,0,0,0)));
    tbl.push_back(mk("x632_no_goal",   1, 1, 632, 1, e(0,1,0,0,1,0,0,0)));
    tbl.push_back(mk("x2_goal",        1, 1,   2, 1, e(1,0,0,0,2,1,0,0)));
    tbl.push_back(mk("after_x2",       1, 0, 320, 1, e(1,0,0,0,2,0,0,0)));
    tbl.push_back(mk("serve_59c",     59, 1, 320, 1, e(1,0,0,0,2,0,0,0)));
    tbl.push_back(mk("serve_60c",      1, 1, 320, 1, e(0,1,0,0,2,0,0,0)));
    tbl.push_back(mk("x633_goal",      1, 1, 633, 1, e(1,0,1,1,2,1,0,0)));
    tbl.push_back(mk("after_x633",     1, 0, 320, 1, e(1,0,1,1,2,0,0,0)));
    tbl.push_back(mk("start_in_serve", 4, 0, 320, 0, e(1,0,1,1,2,0,0,0)));
    tbl.push_back(mk("release_serve",  3, 0, 320, 1, e(1,0,1,1,2,0,0,0)));

    // Reset state
    repeat (3) @(posedge clk_50);
    #1;
    chk("reset_values", e(1,0,0,0,0,0,0,0));
    @(negedge clk_50);
    reset = 1'b0;
    step(1'b1, 10'd0, 1'b1);
    chk("idle_ignores_tick", e(1,0,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        step(tbl[i].tick, tbl[i].bx, tbl[i].btn_n);
        chk(tbl[i].name, tbl[i].exp);
      end
    end

    // Reach 3/2 in PLAY, then hit reset between edges.
    serve_to_play(4'd1, 4'd2, 1'b1);
    p1_point(4'd2, 4'd2);
    serve_to_play(4'd2, 4'd2, 1'b1);
    p1_point(4'd3, 4'd2);
    serve_to_play(4'd3, 4'd2, 1'b1);
    chk("pre_reset_play", e(0,1,1,3,2,0,0,0));
    @(negedge clk_50);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", e(1,0,0,0,0,0,0,0));
    @(negedge clk_50);
    reset = 1'b0;
    press_start("restart_after_reset", e(1,0,1,0,0,0,0,0));

    // Full P1 win: seven points, each after a full serve.
    for (int p = 1; p <= 7; p++) begin
      serve_to_play(4'(p - 1), 4'd0, 1'b1);
      p1_point(4'(p), 4'd0);
    end
    step(1'b1, 10'd1, 1'b1);
    chk("game_over_ignores_tick", e(1,0,1,7,0,0,1,0));
    step(1'b1, 10'd634, 1'b1);
    chk("game_over_frozen", e(1,0,1,7,0,0,1,0));
    press_start("rematch", e(1,0,1,0,0,0,0,0));
    serve_to_play(4'd0, 4'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the Pong datapath. It owns the match flow: idle/attract, serve delay, live play, point scoring, and game over. It watches the ball X position once per frame, keeps both players' scores, and tells the ball mover when to hold the ball at centre, when to run it, and which way to serve. It sits between the button inputs, the ball mover and the score/pixel renderer.

Parameters:
SERVE_FRAMES, 60, frame ticks the ball is held at centre before each serve; must be 1 or more.
WIN_SCORE, 7, score that ends the match; range 1..15.
GOAL_LEFT_X, 2, a ball_x at or below this value is a point for P2.
GOAL_RIGHT_X, 633, a ball_x at or above this value is a point for P1.

Ports:
clk_50  in  1  system clock; all flops on rising edge.
reset  in  1  asynchronous, active-high reset.
frame_tick  in  1  one-cycle pulse per video frame (clk_50 domain).
ball_x  in  10  current ball left-edge X; valid whenever frame_tick=1.
start_btn_n  in  1  raw start button, active-low, asynchronous to clk_50.
ball_hold  out  1  1 = ball mover forces the ball to centre and freezes it.
ball_run  out  1  1 = ball mover advances the ball.
serve_dir  out  1  0 = serve toward P1 (left), 1 = serve toward P2 (right).
score_p1  out  4  P1 score.
score_p2  out  4  P2 score.
point_pulse  out  1  one-cycle pulse when any point is awarded.
game_over  out  1  1 while in GAME_OVER.
winner  out  1  0 = P1, 1 = P2; valid while game_over=1.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state = IDLE
  - ball_hold = 1, ball_run = 0
  - serve_dir = 0
  - score_p1 = 0, score_p2 = 0
  - point_pulse = 0, game_over = 0, winner = 0
  - serve counter = 0
  - sync flops = 1 (button released)
- Start synchroniser: 2-flop sync, then a falling-edge detect produces start_pulse.
  - If start_btn_n is low at edge k, the FSM changes state at edge k+2.
  - Holding the button low produces exactly one pulse.
- All outputs are registered. ball_run = (state==PLAY). ball_hold = not ball_run.
- IDLE:
  - On start_pulse: clear both scores, serve_dir = 1, load serve counter 0, go to SERVE.
- SERVE:
  - On each frame_tick the counter increments.
  - On the frame_tick where counter == SERVE_FRAMES-1, go to PLAY.
  - The ball is therefore held for exactly SERVE_FRAMES ticks.
  - Counter width is clog2(SERVE_FRAMES+1).
- PLAY:
  - ball_x is evaluated only in cycles with frame_tick=1.
  - ball_x <= GOAL_LEFT_X: score_p2 += 1, serve_dir = 0 (serve toward the player who conceded), go to POINT.
  - Else if ball_x >= GOAL_RIGHT_X: score_p1 += 1, serve_dir = 1, go to POINT.
  - Left check has priority if the parameters ever overlap.
- POINT (exactly one cycle):
  - point_pulse = 1 during this cycle.
  - If the scorer's score == WIN_SCORE: winner = scorer, go to GAME_OVER.
  - Otherwise load serve counter 0 and go to SERVE.
- GAME_OVER:
  - game_over = 1; scores frozen.
  - On start_pulse: clear scores, game_over = 0, serve_dir = !winner, go to SERVE.
- Start pulses in SERVE, PLAY or POINT are ignored.
- frame_tick in IDLE or GAME_OVER has no effect.
- Scores never exceed WIN_SCORE; the increment is 4-bit with no wrap reachable.
- Reset mid-operation from any state returns to the reset values with no pending point or start.

Decomposition:
- Package pong_pkg holds:
  - state enum {IDLE, SERVE, PLAY, POINT, GAME_OVER}
  - SCORE_W = 4
  - screen constants SCREEN_W = 640, SCREEN_H = 480
- One sub-module, pong_btn_edge: 2-flop synchroniser plus falling-edge pulse generator, with the same clk_50/reset. It is reused later for the paddle buttons.

Test Plan:
1. Reset, then start_btn_n falls at edge k and stays low -> SERVE at k+2, scores 0/0, ball_hold=1, serve_dir=1, exactly one start pulse.
2. In SERVE with SERVE_FRAMES=60: 59 frame_ticks -> ball_run stays 0; 60th tick -> ball_run=1 on the next cycle.
3. In PLAY, ball_x=1 with no tick -> no change; ball_x=1 with frame_tick -> score_p2=1, point_pulse high for 1 cycle, serve_dir=0, back in SERVE.
4. Award seven P1 points (ball_x=634 plus tick, each followed by a full serve) -> after the 7th: game_over=1, winner=0, ball_hold=1; a further start press -> scores 0/0, serve_dir=1, SERVE.
5. In PLAY, ball_x=320 with frame_tick and a start press -> no state or score change.
6. Assert reset mid-PLAY with score 3/2 (asynchronously, between edges) -> all outputs at reset values before the next clock edge; release, then a start press begins a new match.
